// File: rtl/scatter_hls_deadlock_token_ctrl_pkg.sv
// rtl/scatter_hls_deadlock_token_ctrl_pkg.sv - shared state encoding and defaults for the token controller
package scatter_hls_deadlock_token_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, WAIT, CONFIRM, ABORT, HOLD} state_t;

  localparam int DEF_PROC_NUM = 4;
  localparam int DEF_TIMEOUT  = 64;
  localparam int TIMER_W      = 16;
endpackage

// File: rtl/scatter_hls_deadlock_rr_arb.sv
// rtl/scatter_hls_deadlock_rr_arb.sv - combinational round-robin selector starting at ptr
module scatter_hls_deadlock_rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  int cand;

  // Walk from the farthest offset back to ptr so the closest requester is written last.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = 0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end
endmodule

// File: rtl/scatter_hls_deadlock_token_ctrl.sv
// rtl/scatter_hls_deadlock_token_ctrl.sv - grants one deadlock token round at a time and latches confirmed deadlocks
module scatter_hls_deadlock_token_ctrl
  import scatter_hls_deadlock_token_ctrl_pkg::*;
#(
  parameter int PROC_NUM = DEF_PROC_NUM,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int ID_W     = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_ret_vec,
  input  logic                report_clear,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic [PROC_NUM-1:0] token_clear_vec,
  output logic                dl_detect_bcast,
  output logic                deadlock_flag,
  output logic [ID_W-1:0]     deadlock_proc_id,
  output logic                deadlock_irq
);
  localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]    ID_LAST = ID_W'(PROC_NUM - 1);

  state_t               state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      g;
  logic [TIMER_W-1:0]   timer;
  logic [PROC_NUM-1:0]  arb_grant;
  logic [ID_W-1:0]      arb_idx;
  logic [PROC_NUM-1:0]  g_onehot;
  logic [ID_W-1:0]      next_ptr;

  scatter_hls_deadlock_rr_arb #(.N(PROC_NUM), .IW(ID_W)) u_arb (
    .req   (dl_detect_vec),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign g_onehot = PROC_NUM'(1) << g;
  assign next_ptr = (g == ID_LAST) ? '0 : g + 1'b1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      g                <= '0;
      timer            <= '0;
      origin_vec       <= '0;
      token_clear_vec  <= '0;
      dl_detect_bcast  <= 1'b0;
      deadlock_flag    <= 1'b0;
      deadlock_proc_id <= '0;
      deadlock_irq     <= 1'b0;
    end else begin
      origin_vec      <= '0;
      token_clear_vec <= '0;
      deadlock_irq    <= 1'b0;
      case (state)
        IDLE: if (|dl_detect_vec) begin
          state           <= GRANT;
          g               <= arb_idx;
          origin_vec      <= arb_grant;
          dl_detect_bcast <= 1'b1;
        end
        GRANT: begin
          state <= WAIT;
          timer <= '0;
        end
        // Confirm is tested first so it wins over a timeout in the same cycle.
        WAIT: if (dl_detect_vec[g] && token_ret_vec[g]) begin
          state           <= CONFIRM;
          token_clear_vec <= g_onehot;
          deadlock_irq    <= 1'b1;
        end else if (timer == TO_LAST) begin
          state           <= ABORT;
          token_clear_vec <= '1;
          dl_detect_bcast <= 1'b0;
        end else if (timer != '1) begin
          timer <= timer + 1'b1;
        end
        CONFIRM: begin
          state            <= HOLD;
          deadlock_flag    <= 1'b1;
          deadlock_proc_id <= g;
        end
        ABORT: begin
          state  <= IDLE;
          rr_ptr <= next_ptr;
        end
        HOLD: if (report_clear) begin
          state            <= IDLE;
          deadlock_flag    <= 1'b0;
          deadlock_proc_id <= '0;
          rr_ptr           <= next_ptr;
          dl_detect_bcast  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/scatter_hls_deadlock_token_ctrl.md
SCATTER_HLS_DEADLOCK_TOKEN_CTRL -- requirements
Module: scatter_hls_deadlock_token_ctrl

Interface
REQ-001 The block SHALL have parameter PROC_NUM, default 4, giving the number of deadlock detect units served.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum WAIT cycles before a token round is aborted; legal range 2..65535.
REQ-003 The block SHALL have parameter ID_W, default $clog2(PROC_NUM) (minimum 1), giving the width of the reported process ID.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-006 dl_detect_vec  in  PROC_NUM  bit i is the dl_detect_out of detect unit i.
REQ-007 token_ret_vec  in  PROC_NUM  bit i is the OR of unit i's token_in_vec, meaning the token has arrived at unit i.
REQ-008 report_clear  in  1  software pulse that clears the sticky report.
REQ-009 origin_vec  out  PROC_NUM  one-hot, single-cycle origin pulse, one bit per unit.
REQ-010 token_clear_vec  out  PROC_NUM  single-cycle token_clear pulse, one bit per unit.
REQ-011 dl_detect_bcast  out  1  broadcast to the dl_detect_in of every unit.
REQ-012 deadlock_flag  out  1  sticky flag meaning a deadlock is confirmed.
REQ-013 deadlock_proc_id  out  ID_W  index of the origin process of the confirmed deadlock.
REQ-014 deadlock_irq  out  1  single-cycle pulse issued on confirmation.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, GRANT, WAIT, CONFIRM, ABORT and HOLD.
REQ-016 In IDLE with dl_detect_vec nonzero, the FSM SHALL select grant index g by round-robin and go to GRANT on the next edge.
  - Round-robin search starts at rr_ptr; at reset rr_ptr = 0.
REQ-017 In GRANT, origin_vec SHALL equal 1<<g for exactly one cycle and dl_detect_bcast SHALL be set; the FSM SHALL then go to WAIT.
  - Cycle timing: detect is seen in IDLE at cycle t; origin is asserted at t+1.
REQ-018 dl_detect_bcast SHALL be a register that is 1 from GRANT through WAIT, CONFIRM and HOLD, and 0 in IDLE and ABORT.
REQ-019 WAIT SHALL go to CONFIRM when token_ret_vec[g] and dl_detect_vec[g] are both 1 in the same cycle.
  - A registered timer counts WAIT cycles from 0.
  - The timer saturates, never wraps.
REQ-020 WAIT SHALL go to ABORT when the timer reaches TIMEOUT-1 without the CONFIRM condition.
  - If the CONFIRM condition and the timeout occur in the same cycle, CONFIRM wins.
REQ-021 In CONFIRM (one cycle), the block SHALL do all of the following in that single cycle:
  - drive token_clear_vec = 1<<g;
  - pulse deadlock_irq;
  - set deadlock_flag = 1 and deadlock_proc_id = g, both visible from the next cycle;
  - go to HOLD.
REQ-022 In ABORT (one cycle), the block SHALL drive token_clear_vec to all ones, set rr_ptr = (g+1) mod PROC_NUM and go to IDLE.
REQ-023 HOLD SHALL remain until report_clear = 1; it then clears deadlock_flag and deadlock_proc_id to 0, sets rr_ptr = (g+1) mod PROC_NUM and goes to IDLE.
REQ-024 report_clear SHALL be ignored in every state other than HOLD.
REQ-025 origin_vec SHALL be zero outside GRANT, and token_clear_vec SHALL be zero outside CONFIRM and ABORT.
REQ-026 A change in dl_detect_vec bits other than g SHALL have no effect during GRANT, WAIT or CONFIRM.
REQ-027 rr_ptr arithmetic SHALL wrap modulo PROC_NUM, including when PROC_NUM is not a power of two.

Reset
REQ-028 While reset = 0 at a clock edge, the block SHALL apply the following values at that edge:
  - state = IDLE, rr_ptr = 0, timer = 0, g = 0;
  - origin_vec = 0, token_clear_vec = 0, dl_detect_bcast = 0;
  - deadlock_flag = 0, deadlock_proc_id = 0, deadlock_irq = 0.
REQ-029 A reset asserted mid-round SHALL abandon the round without issuing token_clear, and inputs SHALL be ignored until the first edge with reset = 1.
REQ-030 All outputs SHALL be registered and SHALL hold their reset values while reset is low.

Structure
REQ-031 A shared package SHALL hold the state enumeration (encoding not fixed) and the TIMEOUT and PROC_NUM defaults.
REQ-032 The round-robin priority selector SHALL be a sub-module named scatter_hls_deadlock_rr_arb.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and binary index.
  - Purely combinational.
REQ-033 All FSM, timer and report registers SHALL reside in the top module.

Verification
REQ-034 Confirm path: PROC_NUM=4, dl_detect_vec=0010 at cycle 5 SHALL produce the following, and with report_clear at cycle 20, IDLE at cycle 21:
  - origin_vec=0010 at cycle 6;
  - token_ret_vec[1] and dl_detect_vec[1] both 1 at cycle 10 gives token_clear_vec=0010 and deadlock_irq at cycle 11;
  - deadlock_flag=1 and deadlock_proc_id=1 from cycle 12.
REQ-035 Timeout path: TIMEOUT=8, a grant to unit 2 with no token return SHALL enter ABORT after 8 WAIT cycles, with token_clear_vec=1111 and dl_detect_bcast=0 in ABORT, and rr_ptr=3.
REQ-036 Round-robin: dl_detect_vec=1001 held constant across rounds SHALL grant the units in the order 0, 3, 0, with each round ending in ABORT.
REQ-037 Simultaneous events: the CONFIRM condition on the timeout cycle SHALL yield CONFIRM, and report_clear asserted during WAIT SHALL change nothing.
REQ-038 Reset mid-round: reset=0 during WAIT SHALL yield all outputs 0 on the next edge, and no token_clear pulse SHALL appear before the next GRANT.
REQ-039 Wrap: PROC_NUM=3 with a grant to unit 2 followed by ABORT SHALL give rr_ptr=0.
